// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the dual-port SRAM model.
//   RDW_READ_FIRST    : a read that collides with a write on the other port
//                       returns the word as it was before the write.
//   RDW_WRITE_THROUGH : the colliding read returns the word with the other
//                       port's written byte lanes merged in.
//   lane_merge()      : selects between the stored byte and the write byte
//                       for one lane, based on that lane's write enable.
// ----------------------------------------------------------------------------
package sram_pkg;

    localparam int RDW_READ_FIRST    = 0;
    localparam int RDW_WRITE_THROUGH = 1;

    function automatic logic [7:0] lane_merge(
        input logic [7:0] data,
        input logic [7:0] wdata,
        input logic       mask
    );
        return mask ? wdata : data;
    endfunction

endpackage

// File: rtl/sram_rdpipe.sv
// ----------------------------------------------------------------------------
// sram_rdpipe
// Per-port read output stage. Takes the raw array word and a read-accept
// flag and produces rdata/rvalid after READ_LATENCY clock edges.
//   clk     : clock, rising edge
//   rstz    : asynchronous active-low reset, clears all pipeline state
//   rd_acc  : a read was accepted this cycle
//   rd_word : word read from the array for that access
//   rdata   : read data; holds its value until the next read completes
//   rvalid  : one-cycle strobe per completed read
// ----------------------------------------------------------------------------
module sram_rdpipe
    import sram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             rd_acc,
    input  logic [WIDTH-1:0] rd_word,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] stage_reg;
            logic             stage_vld_reg;

            // A reset between accept and output clears the stage valid, so a
            // read accepted before reset never produces a strobe afterwards.
            always_ff @(posedge clk or negedge rstz) begin
                if (!rstz) begin
                    stage_reg     <= '0;
                    stage_vld_reg <= 1'b0;
                    rdata         <= '0;
                    rvalid        <= 1'b0;
                end else begin
                    stage_vld_reg <= rd_acc;
                    if (rd_acc) begin
                        stage_reg <= rd_word;
                    end
                    rvalid <= stage_vld_reg;
                    if (stage_vld_reg) begin
                        rdata <= stage_reg;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rstz) begin
                if (!rstz) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc;
                    if (rd_acc) begin
                        rdata <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dpsram_model.sv
// ----------------------------------------------------------------------------
// dpsram_model
// Byte-addressable true dual-port SRAM, one clock, parametrised width/depth.
//   clk                 : clock, rising edge
//   rstz                : asynchronous active-low reset (output stage only,
//                         memory contents are not cleared)
//   x_en                : access request (x = a or b)
//   x_addr              : byte address; word index = addr[LSB +: D]
//   x_wdata             : write data
//   x_wr_en             : 1 = write, 0 = read
//   x_wr_mask           : byte-lane write enables
//   x_rdata / x_rvalid  : read data and one-cycle valid strobe
// Port A wins byte lanes written by both ports in the same cycle.
// RDW_MODE selects what a read sees when the other port writes the same word
// in the same cycle: old word (0) or word with written lanes merged (1).
// ----------------------------------------------------------------------------
module dpsram_model
    import sram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int WORDS        = 256,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic               clk,
    input  logic               rstz,
    input  logic               a_en,
    input  logic [31:0]        a_addr,
    input  logic [WIDTH-1:0]   a_wdata,
    input  logic               a_wr_en,
    input  logic [WIDTH/8-1:0] a_wr_mask,
    output logic [WIDTH-1:0]   a_rdata,
    output logic               a_rvalid,
    input  logic               b_en,
    input  logic [31:0]        b_addr,
    input  logic [WIDTH-1:0]   b_wdata,
    input  logic               b_wr_en,
    input  logic [WIDTH/8-1:0] b_wr_mask,
    output logic [WIDTH-1:0]   b_rdata,
    output logic               b_rvalid
);

    localparam int NB  = WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int D   = $clog2(WORDS);

    // Reject unsupported configurations at elaboration.
    generate
        if (WIDTH < 8 || WIDTH > 128 || (WIDTH % 8) != 0) begin : g_bad_width
            $fatal(1, "dpsram_model: WIDTH must be a multiple of 8 in 8..128");
        end
        if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
            $fatal(1, "dpsram_model: WORDS must be a power of two >= 2");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
            $fatal(1, "dpsram_model: READ_LATENCY must be 1 or 2");
        end
        if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_THROUGH) begin : g_bad_rdw
            $fatal(1, "dpsram_model: RDW_MODE must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [WORDS];

    logic [D-1:0]     a_idx;
    logic [D-1:0]     b_idx;
    logic             a_rd;
    logic             a_wr;
    logic             b_rd;
    logic             b_wr;
    logic             same_word;
    logic [WIDTH-1:0] a_word_raw;
    logic [WIDTH-1:0] b_word_raw;
    logic [WIDTH-1:0] a_word_thru;
    logic [WIDTH-1:0] b_word_thru;
    logic [WIDTH-1:0] a_rd_word;
    logic [WIDTH-1:0] b_rd_word;
    logic             addr_unused;

    // Sub-word and above-depth address bits do not select anything; the
    // reduction only keeps them formally consumed.
    assign addr_unused = ^{a_addr, b_addr};

    assign a_idx     = a_addr[LSB +: D];
    assign b_idx     = b_addr[LSB +: D];
    assign a_wr      = a_en &  a_wr_en;
    assign a_rd      = a_en & ~a_wr_en;
    assign b_wr      = b_en &  b_wr_en;
    assign b_rd      = b_en & ~b_wr_en;
    assign same_word = (a_idx == b_idx);

    assign a_word_raw = mem[a_idx];
    assign b_word_raw = mem[b_idx];

    // Each port's read word with the other port's write lanes merged in,
    // used only for the write-through collision case.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign a_word_thru[gi*8 +: 8] = lane_merge(a_word_raw[gi*8 +: 8],
                                                       b_wdata[gi*8 +: 8],
                                                       b_wr_mask[gi]);
            assign b_word_thru[gi*8 +: 8] = lane_merge(b_word_raw[gi*8 +: 8],
                                                       a_wdata[gi*8 +: 8],
                                                       a_wr_mask[gi]);
        end
    endgenerate

    always_comb begin
        a_rd_word = a_word_raw;
        b_rd_word = b_word_raw;
        if (RDW_MODE == RDW_WRITE_THROUGH) begin
            if (b_wr && same_word) begin
                a_rd_word = a_word_thru;
            end
            if (a_wr && same_word) begin
                b_rd_word = b_word_thru;
            end
        end
    end

    // Port B lanes are scheduled first so that port A's assignments to the
    // same lanes override them when both ports write the same word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (b_wr && b_wr_mask[i]) begin
                mem[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
            if (a_wr && a_wr_mask[i]) begin
                mem[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
    end

    sram_rdpipe #(
        .WIDTH        (WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_a (
        .clk     (clk),
        .rstz    (rstz),
        .rd_acc  (a_rd),
        .rd_word (a_rd_word),
        .rdata   (a_rdata),
        .rvalid  (a_rvalid)
    );

    sram_rdpipe #(
        .WIDTH        (WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_b (
        .clk     (clk),
        .rstz    (rstz),
        .rd_acc  (b_rd),
        .rd_word (b_rd_word),
        .rdata   (b_rdata),
        .rvalid  (b_rvalid)
    );

endmodule

// File: tb/tb_dpsram_model.sv
// ----------------------------------------------------------------------------
// tb_dpsram_model
// Two instances: u_p (32-bit, 256 words, latency 1, read-first collisions)
// and u_q (64-bit, 16 words, latency 2, write-through collisions).
// Inputs change on the falling edge; outputs are checked on the falling edge
// following the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_dpsram_model;

    logic clk  = 1'b0;
    logic rstz = 1'b0;

    always #5 clk = ~clk;

    // Instance P: WIDTH=32, WORDS=256, READ_LATENCY=1, RDW_MODE=0
    logic        p_a_en, p_a_wr_en, p_b_en, p_b_wr_en;
    logic [31:0] p_a_addr, p_a_wdata, p_a_rdata, p_b_addr, p_b_wdata, p_b_rdata;
    logic [3:0]  p_a_wr_mask, p_b_wr_mask;
    logic        p_a_rvalid, p_b_rvalid;

    // Instance Q: WIDTH=64, WORDS=16, READ_LATENCY=2, RDW_MODE=1
    logic        q_a_en, q_a_wr_en, q_b_en, q_b_wr_en;
    logic [31:0] q_a_addr, q_b_addr;
    logic [63:0] q_a_wdata, q_a_rdata, q_b_wdata, q_b_rdata;
    logic [7:0]  q_a_wr_mask, q_b_wr_mask;
    logic        q_a_rvalid, q_b_rvalid;

    dpsram_model #(.WIDTH(32), .WORDS(256), .READ_LATENCY(1), .RDW_MODE(0)) u_p (
        .clk(clk), .rstz(rstz),
        .a_en(p_a_en), .a_addr(p_a_addr), .a_wdata(p_a_wdata), .a_wr_en(p_a_wr_en),
        .a_wr_mask(p_a_wr_mask), .a_rdata(p_a_rdata), .a_rvalid(p_a_rvalid),
        .b_en(p_b_en), .b_addr(p_b_addr), .b_wdata(p_b_wdata), .b_wr_en(p_b_wr_en),
        .b_wr_mask(p_b_wr_mask), .b_rdata(p_b_rdata), .b_rvalid(p_b_rvalid)
    );

    dpsram_model #(.WIDTH(64), .WORDS(16), .READ_LATENCY(2), .RDW_MODE(1)) u_q (
        .clk(clk), .rstz(rstz),
        .a_en(q_a_en), .a_addr(q_a_addr), .a_wdata(q_a_wdata), .a_wr_en(q_a_wr_en),
        .a_wr_mask(q_a_wr_mask), .a_rdata(q_a_rdata), .a_rvalid(q_a_rvalid),
        .b_en(q_b_en), .b_addr(q_b_addr), .b_wdata(q_b_wdata), .b_wr_en(q_b_wr_en),
        .b_wr_mask(q_b_wr_mask), .b_rdata(q_b_rdata), .b_rvalid(q_b_rvalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_all();
        p_a_en = 0; p_a_wr_en = 0; p_a_addr = '0; p_a_wdata = '0; p_a_wr_mask = '0;
        p_b_en = 0; p_b_wr_en = 0; p_b_addr = '0; p_b_wdata = '0; p_b_wr_mask = '0;
        q_a_en = 0; q_a_wr_en = 0; q_a_addr = '0; q_a_wdata = '0; q_a_wr_mask = '0;
        q_b_en = 0; q_b_wr_en = 0; q_b_addr = '0; q_b_wdata = '0; q_b_wr_mask = '0;
    endtask

    task automatic pa(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m);
        p_a_en = 1; p_a_wr_en = wr; p_a_addr = addr; p_a_wdata = wd; p_a_wr_mask = m;
    endtask

    task automatic pb(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m);
        p_b_en = 1; p_b_wr_en = wr; p_b_addr = addr; p_b_wdata = wd; p_b_wr_mask = m;
    endtask

    task automatic qa(input logic wr, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] m);
        q_a_en = 1; q_a_wr_en = wr; q_a_addr = addr; q_a_wdata = wd; q_a_wr_mask = m;
    endtask

    task automatic qb(input logic wr, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] m);
        q_b_en = 1; q_b_wr_en = wr; q_b_addr = addr; q_b_wdata = wd; q_b_wr_mask = m;
    endtask

    logic [63:0] q_words [4];

    initial begin
        q_words[0] = 64'hC0DE0000_00001000;
        q_words[1] = 64'hC0DE0001_00001001;
        q_words[2] = 64'hC0DE0002_00001002;
        q_words[3] = 64'hC0DE0003_00001003;

        idle_all();
        rstz = 1'b0;
        #1;
        check_eq("rst_p_a_rdata",  64'(p_a_rdata),  64'h0);
        check_eq("rst_p_a_rvalid", 64'(p_a_rvalid), 64'h0);
        check_eq("rst_p_b_rdata",  64'(p_b_rdata),  64'h0);
        check_eq("rst_p_b_rvalid", 64'(p_b_rvalid), 64'h0);
        check_eq("rst_q_b_rdata",  q_b_rdata,       64'h0);
        check_eq("rst_q_b_rvalid", 64'(q_b_rvalid), 64'h0);
        tick(); tick();
        rstz = 1'b1;
        tick();

        // ---------------- instance P: basic write then read ----------------
        idle_all(); pa(1, 32'h10, 32'hDEADBEEF, 4'hF); tick();
        check_eq("p_wr_no_rvalid", 64'(p_a_rvalid), 64'h0);
        idle_all(); pa(0, 32'h10, 32'h0, 4'h0); tick();
        check_eq("p_rd_data",   64'(p_a_rdata),  64'hDEADBEEF);
        check_eq("p_rd_rvalid", 64'(p_a_rvalid), 64'h1);
        idle_all(); tick();
        check_eq("p_idle_rvalid", 64'(p_a_rvalid), 64'h0);
        check_eq("p_idle_hold",   64'(p_a_rdata),  64'hDEADBEEF);

        // ---------------- byte mask, aliasing, both-read ----------------
        idle_all(); pb(1, 32'h20, 32'h11223344, 4'hF); tick();
        idle_all(); pa(1, 32'h20, 32'hAABBCCDD, 4'b0101); tick();
        idle_all(); pa(0, 32'h420, 32'h0, 4'h0); pb(0, 32'h20, 32'h0, 4'h0); tick();
        check_eq("p_mask_alias_a", 64'(p_a_rdata), 64'h11BB33DD);
        check_eq("p_both_read_b",  64'(p_b_rdata), 64'h11BB33DD);
        check_eq("p_both_rvalid",  64'({p_a_rvalid, p_b_rvalid}), 64'h3);
        idle_all(); pa(1, 32'h20, 32'hFFFFFFFF, 4'h0); tick();
        idle_all(); pa(0, 32'h22, 32'h0, 4'h0); tick();
        check_eq("p_mask0_noop", 64'(p_a_rdata), 64'h11BB33DD);

        // ---------------- both ports write the same word ----------------
        idle_all(); pa(1, 32'h40, 32'h12345678, 4'hF); tick();
        idle_all(); pa(1, 32'h40, 32'hAAAAAAAA, 4'b0011); pb(1, 32'h40, 32'hBBBBBBBB, 4'b0110); tick();
        idle_all(); pa(0, 32'h40, 32'h0, 4'h0); tick();
        check_eq("p_ww_collision", 64'(p_a_rdata), 64'h12BBAAAA);

        // ---------------- read-first collisions ----------------
        idle_all(); pa(1, 32'h80, 32'h0, 4'hF); tick();
        idle_all(); pa(1, 32'h80, 32'hFFFFFFFF, 4'hF); pb(0, 32'h80, 32'h0, 4'h0); tick();
        check_eq("p_rdw_b_old",    64'(p_b_rdata),  64'h0);
        check_eq("p_rdw_b_rvalid", 64'(p_b_rvalid), 64'h1);
        check_eq("p_rdw_a_nov",    64'(p_a_rvalid), 64'h0);
        idle_all(); pb(1, 32'h80, 32'h55555555, 4'hF); pa(0, 32'h80, 32'h0, 4'h0); tick();
        check_eq("p_rdw_a_old", 64'(p_a_rdata), 64'hFFFFFFFF);
        idle_all(); pa(0, 32'h83, 32'h0, 4'h0); tick();
        check_eq("p_rdw_after", 64'(p_a_rdata), 64'h55555555);

        // ---------------- instance Q: preload and stream ----------------
        for (int k = 0; k < 4; k++) begin
            idle_all(); qa(1, 32'(k * 8), q_words[k], 8'hFF); tick();
        end
        for (int k = 0; k < 6; k++) begin
            idle_all();
            if (k < 4) qb(0, 32'(k * 8), 64'h0, 8'h0);
            tick();
            if (k == 0) begin
                check_eq("q_stream_lat", 64'(q_b_rvalid), 64'h0);
            end else if (k <= 4) begin
                check_eq($sformatf("q_stream_v%0d", k - 1), 64'(q_b_rvalid), 64'h1);
                check_eq($sformatf("q_stream_d%0d", k - 1), q_b_rdata, q_words[k - 1]);
            end else begin
                check_eq("q_stream_end_v", 64'(q_b_rvalid), 64'h0);
                check_eq("q_stream_hold",  q_b_rdata, q_words[3]);
            end
        end

        // ---------------- write-through collision ----------------
        idle_all(); qa(1, 32'h0, 64'hFFFFFFFF_FFFFFFFF, 8'hF0); qb(0, 32'h0, 64'h0, 8'h0); tick();
        check_eq("q_rdw_lat", 64'(q_b_rvalid), 64'h0);
        idle_all(); tick();
        check_eq("q_rdw_new",    q_b_rdata,       64'hFFFFFFFF_00001000);
        check_eq("q_rdw_rvalid", 64'(q_b_rvalid), 64'h1);

        // ---------------- reset between accept and output ----------------
        idle_all(); qb(0, 32'h08, 64'h0, 8'h0); tick();
        idle_all(); rstz = 1'b0; #1;
        check_eq("q_rst_rdata",  q_b_rdata,       64'h0);
        check_eq("q_rst_rvalid", 64'(q_b_rvalid), 64'h0);
        tick();
        rstz = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("q_no_strobe%0d", k), 64'(q_b_rvalid), 64'h0);
        end
        idle_all(); qb(0, 32'h88, 64'h0, 8'h0); tick();
        idle_all(); tick();
        check_eq("q_kept_data",   q_b_rdata,       q_words[1]);
        check_eq("q_kept_rvalid", 64'(q_b_rvalid), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
